// File: rtl/processor.sv
// processor: instruction-fetch front end of a Y86-style teaching core.
// Holds a 512 x 32 instruction memory that is loadable while idle, and fetches
// one word per clock while `working` is high, presenting the decoded fields as
// registered outputs.
// Optional feature macro: PROC_PC_WRAP_EN (pc wraps 511 -> 0; default saturates).
module processor (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  addr,
    input  logic        wEn,
    input  logic [31:0] wDat,
    input  logic        working,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [15:0] valC
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [8:0] LastAddr = 9'd511;

    logic [31:0] mem [0:511];

    state_e      state_q;
    logic [8:0]  pc_q;
    logic [8:0]  pc_d;
    logic [8:0]  fa;
    logic [31:0] insn_q;

    // Fetch address: the first working edge of a run starts from addr, later ones from pc.
    always_comb begin
        fa = (state_q == StRun) ? pc_q : addr;
`ifdef PROC_PC_WRAP_EN
        pc_d = fa + 9'd1;
`else
        pc_d = (fa == LastAddr) ? LastAddr : fa + 9'd1;
`endif
    end

    // Load port: writes are only honoured while the core is idle; reset never touches memory.
    always_ff @(posedge clock) begin
        if (wEn && !working) begin
            mem[addr] <= wDat;
        end
    end

    // Run/idle state, pc and the registered instruction word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= 9'd0;
            insn_q  <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (working) begin
                        insn_q  <= mem[fa];
                        pc_q    <= pc_d;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (working) begin
                        insn_q <= mem[fa];
                        pc_q   <= pc_d;
                    end else begin
                        // A pause ends the run; re-asserting working restarts from addr.
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign icode = insn_q[31:28];
    assign ifun  = insn_q[27:24];
    assign rA    = insn_q[23:20];
    assign rB    = insn_q[19:16];
    assign valC  = insn_q[15:0];

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed steps, expected words queued when
// each edge is driven and compared once the edge has been taken.
module tb_processor;

    logic        clock;
    logic        reset;
    logic [8:0]  addr;
    logic        wEn;
    logic [31:0] wDat;
    logic        working;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [15:0] valC;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];

    processor dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .wEn     (wEn),
        .wDat    (wDat),
        .working (working),
        .icode   (icode),
        .ifun    (ifun),
        .rA      (rA),
        .rB      (rB),
        .valC    (valC)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [31:0] outs();
        return {icode, ifun, rA, rB, valC};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One edge with the current inputs; the outputs after it must equal want.
    task automatic edge_expect(input string tag, input logic [31:0] want);
        logic [31:0] w;
        exp_q.push_back(want);
        @(posedge clock);
        #1;
        w = exp_q.pop_front();
        check(tag, outs(), w);
    endtask

    task automatic write_word(input logic [8:0] a, input logic [31:0] d);
        working = 1'b0;
        addr    = a;
        wDat    = d;
        wEn     = 1'b1;
        @(posedge clock);
        #1;
        wEn = 1'b0;
    endtask

    task automatic go_idle();
        working = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        addr    = 9'd0;
        wEn     = 1'b0;
        wDat    = 32'd0;
        working = 1'b0;

        // Reset with no other activity.
        #25;
        check("reset_outs", outs(), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("post_reset_idle", outs(), 32'h0);

        // Load three words, then fetch them.
        write_word(9'd0, 32'h10f50008);
        write_word(9'd1, 32'h21450000);
        write_word(9'd2, 32'h20120000);
        check("load_no_fetch", outs(), 32'h0);
        addr    = 9'd0;
        working = 1'b1;
        edge_expect("fetch0", 32'h10f50008);
        addr = 9'h1ab;  // ignored during a run
        edge_expect("fetch1", 32'h21450000);
        edge_expect("fetch2", 32'h20120000);
        go_idle();

        // Pause after two fetches: outputs hold.
        addr    = 9'd0;
        working = 1'b1;
        edge_expect("pause_f0", 32'h10f50008);
        edge_expect("pause_f1", 32'h21450000);
        working = 1'b0;
        edge_expect("hold_1", 32'h21450000);
        edge_expect("hold_2", 32'h21450000);
        addr    = 9'd2;
        working = 1'b1;
        edge_expect("restart_addr2", 32'h20120000);
        go_idle();

        // Write protection while working.
        addr    = 9'd1;
        wDat    = 32'hffffffff;
        wEn     = 1'b1;
        working = 1'b1;
        edge_expect("wp_fetch1", 32'h21450000);
        wEn = 1'b0;
        edge_expect("wp_fetch2", 32'h20120000);
        go_idle();
        addr    = 9'd1;
        working = 1'b1;
        edge_expect("wp_refetch1", 32'h21450000);
        go_idle();

        // End-of-memory behaviour.
        write_word(9'd511, 32'h30000001);
        write_word(9'd0, 32'h40000002);
        addr    = 9'd511;
        working = 1'b1;
        edge_expect("top_first", 32'h30000001);
`ifdef PROC_PC_WRAP_EN
        edge_expect("top_second", 32'h40000002);
        edge_expect("top_third", 32'h21450000);
`else
        edge_expect("top_second", 32'h30000001);
        edge_expect("top_third", 32'h30000001);
`endif
        go_idle();

        // Reset mid-run clears outputs immediately; restart fetches from addr.
        addr    = 9'd1;
        working = 1'b1;
        edge_expect("mr_fetch", 32'h21450000);
        reset = 1'b1;
        #2;
        check("mr_async_clear", outs(), 32'h0);
        @(posedge clock);
        #1;
        check("mr_held_in_reset", outs(), 32'h0);
        addr  = 9'd2;
        reset = 1'b0;
        edge_expect("mr_after_release", 32'h20120000);
        go_idle();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor.md
# processor

Instruction-fetch front end of the teaching Y86-style processor. Contains a 512-word × 32-bit instruction memory loaded through a simple write port while the core is idle. When `working` is asserted it fetches one word per clock from a program counter and presents the decoded fields `icode`, `ifun`, `rA`, `rB` and `valC` as registered outputs. Later pipeline stages consume these outputs.

## Interface
Parameters: none. Depth is fixed at 512 words and width at 32 bits.

Ports:
- `clock`, input, 1: single system clock, rising-edge active; nominally 50 MHz.
- `reset`, input, 1: asynchronous, active-high reset.
- `addr`, input, 9: word address. Used for memory writes, and as the start PC on the first fetch cycle.
- `wEn`, input, 1: memory write enable.
- `wDat`, input, 32: memory write data.
- `working`, input, 1: 1 = fetch enabled; 0 = idle/load mode.
- `icode`, output, 4: instruction word bits [31:28].
- `ifun`, output, 4: bits [27:24].
- `rA`, output, 4: bits [23:20].
- `rB`, output, 4: bits [19:16].
- `valC`, output, 16: bits [15:0].

## Operation
- Memory: `mem[0:511]`, 32 bits, word addressed, asynchronous read.
  - Memory contents are not affected by `reset`.
  - Memory contents are undefined until written.
- Write rule:
  - On a rising edge with `wEn`=1 and `working`=0, `mem[addr] <= wDat`.
  - `wEn` is ignored while `working`=1, so the memory is write-protected during execution.
- Internal state:
  - `pc[8:0]`.
  - `started` flag, 1 after the first fetch of a run.
- Fetch address `fa = started ? pc : addr`.
- Rising edge with `working`=1:
  - `{icode,ifun,rA,rB,valC} <= mem[fa]`
  - `pc <= fa+1`
  - `started <= 1`
- Rising edge with `working`=0:
  - `started <= 0`.
  - `pc` and all outputs hold their values.
- Two states, derived from `started`:
  - IDLE (`started`=0): moves to RUN on the first working edge.
  - RUN (`started`=1): returns to IDLE on any edge with `working`=0.
- Re-asserting `working` after a pause restarts fetch from `addr`; it does not resume from `pc`.
- No instruction-length decoding: every instruction occupies exactly one word and `pc` always advances by 1.

## Timing
- Reset (asynchronous, immediate): `pc`=0, `started`=0, all outputs 0.
- Fetch latency:
  - Outputs update at the rising edge where `working`=1, and then on every subsequent edge.
  - The first edge delivers `mem[addr]`; the N-th consecutive edge delivers `mem[addr+N-1]`.
- A word written at edge k can be fetched at edge k+1 or later.
- `addr` is sampled only on the first working edge; changes to `addr` during RUN have no effect.
- Reset asserted mid-run clears state at once. After release, the core is IDLE; if `working` is still 1, the next edge fetches from `addr`.

## Configuration
- `PROC_PC_WRAP_EN` defined: `pc` wraps from 511 to 0.
- Undefined: `pc` saturates at 511 and re-fetches `mem[511]` on every further working cycle.

## Test plan
- Reset with no other activity: all outputs 0.
- Load and fetch:
  - Stimulus:
    - Write `10f50008` to address 0, `21450000` to address 1 and `20120000` to address 2 on three consecutive edges with `working`=0.
    - Then raise `working` with `addr`=0.
  - Required response on the following three edges, as icode/ifun/rA/rB/valC:
    - 1/0/f/5/0008
    - 2/1/4/5/0000
    - 2/0/1/2/0000
- Pause and restart: drop `working` after two fetches.
  - Outputs hold 2/1/4/5/0000.
  - Raise `working` with `addr`=2: the first fetch is 2/0/1/2/0000.
- Write protection: with `working`=1, pulse `wEn`=1, `addr`=1, `wDat`=`ffffffff`.
  - A later fetch of address 1 still returns 2/1/4/5/0000.
- Wrap: write `30000001` to address 511 and `40000002` to address 0, then start at `addr`=511.
  - First edge: icode=3, valC=0001.
  - Second edge with `PROC_PC_WRAP_EN`: icode=4, valC=0002.
  - Second edge without it: icode=3, valC=0001 again.
- Reset mid-run: assert `reset` during RUN.
  - Outputs go to 0 immediately, before the next edge.
  - The first edge after release fetches from `addr`.
